// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: burst tag encodings and a small sizing helper.
// The burst tags are not interpreted by the arbiter; benches and neighbouring blocks use them.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr.sv
// Combinational round-robin pick: the first requester strictly after `last`,
// wrapping to the lowest index. Output is one-hot, or zero with no requests.
module arb_rr #(
    parameter int N  = 2,
    parameter int LW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant
);

    logic [N-1:0] upper;
    logic [N-1:0] upper_req;

    for (genvar gi = 0; gi < N; gi++) begin : g_upper
        assign upper[gi] = (LW'(gi) > last);
    end

    assign upper_req = req & upper;

    // x & -x isolates the lowest set bit; fall back to the full vector on wrap.
    assign grant = (|upper_req) ? (upper_req & (~upper_req + N'(1)))
                                : (req & (~req + N'(1)));

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B3 arbiter: MASTERS masters share one slave port, ownership
// held for the whole cyc period, with a watchdog that errors unanswered strobes.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int MASTERS    = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int TIMEOUT    = 255,
    localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [ADDR_WIDTH*MASTERS-1:0]   m_adr_i,
    input  logic [DATA_WIDTH*MASTERS-1:0]   m_dat_i,
    input  logic [MASTERS-1:0]              m_cyc_i,
    input  logic [MASTERS-1:0]              m_stb_i,
    input  logic [MASTERS-1:0]              m_we_i,
    input  logic [SEL_WIDTH*MASTERS-1:0]    m_sel_i,
    input  logic [3*MASTERS-1:0]            m_cti_i,
    input  logic [2*MASTERS-1:0]            m_bte_i,
    output logic [DATA_WIDTH*MASTERS-1:0]   m_dat_o,
    output logic [MASTERS-1:0]              m_ack_o,
    output logic [MASTERS-1:0]              m_err_o,
    output logic [MASTERS-1:0]              m_rty_o,
    output logic [ADDR_WIDTH-1:0]           s_adr_o,
    output logic [DATA_WIDTH-1:0]           s_dat_o,
    output logic [SEL_WIDTH-1:0]            s_sel_o,
    output logic                            s_we_o,
    output logic [2:0]                      s_cti_o,
    output logic [1:0]                      s_bte_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    input  logic [DATA_WIDTH-1:0]           s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_rty_i,
    output logic [MASTERS-1:0]              grant_o
);

    localparam int LW = idx_width(MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [MASTERS-1:0] grant_reg, grant_next;
    logic [LW-1:0]      last_reg, last_next;
    logic [CW-1:0]      wd_cnt_reg, wd_cnt_next;

    logic [ADDR_WIDTH-1:0] adr_arr [MASTERS];
    logic [DATA_WIDTH-1:0] dat_arr [MASTERS];
    logic [SEL_WIDTH-1:0]  sel_arr [MASTERS];
    logic [2:0]            cti_arr [MASTERS];
    logic [1:0]            bte_arr [MASTERS];
    logic [MASTERS-1:0]    idx_mask [LW];

    logic [LW-1:0]      owner_idx;
    logic [LW-1:0]      arb_last;
    logic [MASTERS-1:0] arb_grant;
    logic               owned;
    logic               own_cyc;
    logic               own_stb;
    logic               s_resp;
    logic               wd_active;
    logic               wd_fire;

    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_unpack
        assign adr_arr[gi] = m_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_arr[gi] = m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign sel_arr[gi] = m_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
        assign cti_arr[gi] = m_cti_i[gi*3 +: 3];
        assign bte_arr[gi] = m_bte_i[gi*2 +: 2];
        assign m_dat_o[gi*DATA_WIDTH +: DATA_WIDTH] = owned ? s_dat_i : '0;
    end

    // One-hot to index: index bit b is set when the owner's number has bit b set.
    for (genvar gb = 0; gb < LW; gb++) begin : g_idx_bit
        for (genvar gi = 0; gi < MASTERS; gi++) begin : g_idx_master
            assign idx_mask[gb][gi] = (((gi >> gb) & 1) != 0);
        end
        assign owner_idx[gb] = |(grant_reg & idx_mask[gb]);
    end

    assign owned     = |grant_reg;
    assign own_cyc   = |(grant_reg & m_cyc_i);
    assign own_stb   = |(grant_reg & m_stb_i);
    assign s_resp    = s_ack_i | s_err_i | s_rty_i;
    assign wd_active = own_cyc & own_stb & ~s_resp;
    assign wd_fire   = (TIMEOUT > 0) && wd_active && (wd_cnt_reg == WD_LAST);

    // While owned the scan starts after the owner, so a release hands over fairly.
    assign arb_last = owned ? owner_idx : last_reg;

    arb_rr #(
        .N  (MASTERS),
        .LW (LW)
    ) u_arb_rr (
        .req   (m_cyc_i),
        .last  (arb_last),
        .grant (arb_grant)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_reg  <= '0;
            last_reg   <= LW'(MASTERS - 1);
            wd_cnt_reg <= '0;
        end else begin
            grant_reg  <= grant_next;
            last_reg   <= last_next;
            wd_cnt_reg <= wd_cnt_next;
        end
    end

    always_comb begin
        grant_next  = grant_reg;
        last_next   = last_reg;
        wd_cnt_next = wd_cnt_reg + CW'(1);
        if (!owned) begin
            if (|m_cyc_i) begin
                grant_next = arb_grant;
            end
        end else if (!own_cyc) begin
            grant_next = arb_grant;
            last_next  = owner_idx;
        end
        if ((grant_next != grant_reg) || !wd_active || wd_fire) begin
            wd_cnt_next = '0;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (owned) begin
            s_adr_o = adr_arr[owner_idx];
            s_dat_o = dat_arr[owner_idx];
            s_sel_o = sel_arr[owner_idx];
            s_we_o  = |(grant_reg & m_we_i);
            s_cti_o = cti_arr[owner_idx];
            s_bte_o = bte_arr[owner_idx];
        end
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        grant_o = grant_reg;
        m_ack_o = grant_reg & {MASTERS{s_ack_i}};
        m_err_o = grant_reg & {MASTERS{s_err_i | wd_fire}};
        m_rty_o = grant_reg & {MASTERS{s_rty_i}};
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (2 masters, watchdog of 4 cycles): directed
// vector table, hand-written multi-cycle sequences, then random traffic against a model.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int NM = 2;
    localparam int TO = 4;

    logic        clk_i;
    logic        rst_ni;
    logic [63:0] m_adr_i;
    logic [63:0] m_dat_i;
    logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [7:0]  m_sel_i;
    logic [5:0]  m_cti_i;
    logic [3:0]  m_bte_i;
    logic [63:0] m_dat_o;
    logic [1:0]  m_ack_o, m_err_o, m_rty_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic        s_cyc_o, s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  grant_o;

    wb_arbiter #(
        .MASTERS    (NM),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_sel_i (m_sel_i),
        .m_cti_i (m_cti_i),
        .m_bte_i (m_bte_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cti_o (s_cti_o),
        .s_bte_o (s_bte_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i),
        .grant_o (grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Vector table: per-cycle inputs and the outputs required during that cycle.
    typedef struct {
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic       err;
        logic       rty;
        logic [1:0] g;
        logic       scyc;
        logic       sstb;
        logic [1:0] ack_e;
        logic [1:0] err_e;
        logic [1:0] rty_e;
    } vec_t;

    vec_t vecs [15];

    // Reference model state: owner (-1 = none), last owner, unanswered-strobe count.
    int mo_owner;
    int mo_last;
    int mo_wait;

    function automatic int pick(input logic [1:0] req, input int start);
        for (int k = 1; k <= NM; k++) begin
            int idx = (start + k) % NM;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_cycle();
        logic [1:0]  eg, eack, eerr, erty;
        logic        escyc, estb, resp, fire;
        logic [31:0] eadr, edat;
        logic [63:0] emdat;
        logic [11:0] ectl, actl;
        int          nxt;
        eg = '0; eack = '0; eerr = '0; erty = '0;
        escyc = 1'b0; estb = 1'b0; fire = 1'b0;
        eadr = '0; edat = '0; emdat = '0; ectl = '0;
        resp = s_ack_i | s_err_i | s_rty_i;
        if (mo_owner >= 0) begin
            eg    = 2'(1 << mo_owner);
            escyc = m_cyc_i[mo_owner];
            estb  = m_stb_i[mo_owner];
            eadr  = m_adr_i[mo_owner*32 +: 32];
            edat  = m_dat_i[mo_owner*32 +: 32];
            ectl  = {m_we_i[mo_owner], m_sel_i[mo_owner*4 +: 4],
                     m_cti_i[mo_owner*3 +: 3], m_bte_i[mo_owner*2 +: 2]};
            emdat = {s_dat_i, s_dat_i};
            fire  = escyc && estb && !resp && (mo_wait == TO - 1);
            if (s_ack_i) eack = eg;
            if (s_err_i || fire) eerr = eg;
            if (s_rty_i) erty = eg;
        end
        actl = {s_we_o, s_sel_o, s_cti_o, s_bte_o};
        check("rnd_grant", grant_o, eg);
        check("rnd_scyc", s_cyc_o, escyc);
        check("rnd_sstb", s_stb_o, estb);
        check("rnd_sadr", s_adr_o, eadr);
        check("rnd_sdat", s_dat_o, edat);
        check("rnd_sctl", actl, ectl);
        check("rnd_mack", m_ack_o, eack);
        check("rnd_merr", m_err_o, eerr);
        check("rnd_mrty", m_rty_o, erty);
        check("rnd_mdat", m_dat_o, emdat);
        tick();
        nxt = mo_owner;
        if (mo_owner < 0) begin
            if (m_cyc_i != 2'b00) nxt = pick(m_cyc_i, mo_last);
        end else if (!m_cyc_i[mo_owner]) begin
            mo_last = mo_owner;
            nxt = pick(m_cyc_i, mo_owner);
        end
        if (nxt != mo_owner) mo_wait = 0;
        else if (mo_owner >= 0 && escyc && estb && !resp && !fire) mo_wait++;
        else mo_wait = 0;
        mo_owner = nxt;
    endtask

    initial begin
        logic [1:0] flip;
        int         r;

        vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00};
        vecs[4]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00};
        vecs[6]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[7]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00};
        vecs[8]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00};
        vecs[10] = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10};
        vecs[11] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[12] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};

        // Reset with random inputs: every output must be zero.
        rst_ni = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_adr_i = {$urandom, $urandom}; m_dat_i = {$urandom, $urandom};
            m_cyc_i = 2'($urandom); m_stb_i = 2'($urandom); m_we_i = 2'($urandom);
            m_sel_i = 8'($urandom); m_cti_i = 6'($urandom); m_bte_i = 4'($urandom);
            s_dat_i = $urandom; s_ack_i = 1'($urandom); s_err_i = 1'($urandom);
            s_rty_i = 1'($urandom);
            #7;
            check("rst_grant", grant_o, 0);
            check("rst_s", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o}, 0);
            check("rst_m", {m_ack_o, m_err_o, m_rty_o}, 0);
            check("rst_mdat", m_dat_o, 0);
            $display("reset cycle %0d: grant=%b s_cyc=%b", i, grant_o, s_cyc_o);
        end
        m_adr_i = {32'h0000_2000, 32'h0000_1000};
        m_dat_i = {32'h2222_2222, 32'h1111_1111};
        m_we_i = 2'b00; m_sel_i = 8'hFF; m_cti_i = '0; m_bte_i = '0;
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Directed table: single request, round robin handovers, err/rty pass-through.
        for (int i = 0; i < 15; i++) begin
            logic [31:0] eadr;
            m_cyc_i = vecs[i].cyc; m_stb_i = vecs[i].stb;
            s_ack_i = vecs[i].ack; s_err_i = vecs[i].err; s_rty_i = vecs[i].rty;
            #2;
            eadr = (vecs[i].g == 2'b01) ? 32'h1000 : (vecs[i].g == 2'b10) ? 32'h2000 : 32'h0;
            check("vec_grant", grant_o, vecs[i].g);
            check("vec_scyc", s_cyc_o, vecs[i].scyc);
            check("vec_sstb", s_stb_o, vecs[i].sstb);
            check("vec_mack", m_ack_o, vecs[i].ack_e);
            check("vec_merr", m_err_o, vecs[i].err_e);
            check("vec_mrty", m_rty_o, vecs[i].rty_e);
            check("vec_sadr", s_adr_o, eadr);
            check("vec_mdat", m_dat_o, (vecs[i].g != 2'b00) ? {2{32'hDEAD_BEEF}} : 64'h0);
            $display("vec %0d: cyc=%b grant=%b s_cyc=%b ack=%b err=%b rty=%b",
                     i, m_cyc_i, grant_o, s_cyc_o, m_ack_o, m_err_o, m_rty_o);
            tick();
        end
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

        // Lock: master 0 keeps cyc for an 8-beat INCR burst while master 1 waits.
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        #2;
        check("lock_pre_grant", grant_o, 2'b00);
        tick();
        for (int b = 0; b < 8; b++) begin
            m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
            m_cti_i = {3'b000, (b == 7) ? CTI_EOB : CTI_INCR};
            #2;
            check("lock_grant", grant_o, 2'b01);
            check("lock_ack", m_ack_o, 2'b01);
            check("lock_cti", s_cti_o, (b == 7) ? CTI_EOB : CTI_INCR);
            $display("lock beat %0d: grant=%b ack=%b cti=%b", b, grant_o, m_ack_o, s_cti_o);
            tick();
        end
        m_cyc_i = 2'b10; m_stb_i = 2'b10; s_ack_i = 1'b0; m_cti_i = '0;
        #2;
        check("lock_rel_grant", grant_o, 2'b01);
        check("lock_rel_scyc", s_cyc_o, 1'b0);
        tick();
        #2;
        check("lock_new_grant", grant_o, 2'b10);
        check("lock_new_scyc", s_cyc_o, 1'b1);
        $display("lock handover: grant=%b s_cyc=%b", grant_o, s_cyc_o);
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        tick();
        tick();

        // Watchdog: silent slave, error pulses in the 4th strobed cycle.
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        tick();
        for (int k = 1; k <= 5; k++) begin
            #2;
            check("wd_err", m_err_o, (k == 4) ? 2'b01 : 2'b00);
            check("wd_ack", m_ack_o, 2'b00);
            $display("watchdog cycle %0d: err=%b", k, m_err_o);
            tick();
        end
        m_stb_i = 2'b00;
        tick();
        m_stb_i = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            s_ack_i = (k == 4);
            #2;
            check("wd_ack_win_err", m_err_o, 2'b00);
            check("wd_ack_win_ack", m_ack_o, (k == 4) ? 2'b01 : 2'b00);
            $display("watchdog+ack cycle %0d: ack=%b err=%b", k, m_ack_o, m_err_o);
            tick();
        end
        s_ack_i = 1'b0;

        // Asynchronous reset in the middle of an owned transfer.
        #2;
        check("arst_pre_scyc", s_cyc_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("arst_scyc", s_cyc_o, 1'b0);
        check("arst_grant", grant_o, 2'b00);
        $display("async reset: grant=%b s_cyc=%b", grant_o, s_cyc_o);
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        #2;
        check("arst_first_grant", grant_o, 2'b01);
        $display("after reset: grant=%b", grant_o);

        // Random traffic against the reference model.
        rst_ni = 1'b0;
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        mo_owner = -1; mo_last = NM - 1; mo_wait = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        for (int c = 0; c < 1500; c++) begin
            flip = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            m_cyc_i = m_cyc_i ^ flip;
            m_stb_i = m_cyc_i & 2'($urandom);
            m_adr_i = {$urandom, $urandom}; m_dat_i = {$urandom, $urandom};
            m_we_i = 2'($urandom); m_sel_i = 8'($urandom);
            m_cti_i = 6'($urandom); m_bte_i = 4'($urandom);
            s_dat_i = $urandom;
            r = $urandom_range(0, 9);
            s_ack_i = (r < 3); s_err_i = (r == 3); s_rty_i = (r == 4);
            #2;
            model_cycle();
        end
        $display("random phase: 1500 cycles applied");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin Wishbone B3 arbiter connecting MASTERS bus masters to one shared slave port. It is the many-masters-to-one counterpart of the address decoder, and the two are chained as master arbiter → wb_decode → slaves.
- Ownership is held for the whole `cyc` period, so bursts and read-modify-write sequences are not interleaved.
- A built-in watchdog terminates transfers the slave never answers with an error response.

## Interface
- MASTERS, 2: number of masters, 1..16.
- DATA_WIDTH, 32: bus data width in bits, multiple of 8.
- ADDR_WIDTH, 32: bus address width in bits.
- TIMEOUT, 255: cycles a strobed transfer may stay unanswered before the arbiter signals an error; 0 disables the watchdog.
- SEL_WIDTH (localparam), DATA_WIDTH/8.

Ports:
- clk_i  in  1  bus clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- m_adr_i  in  ADDR_WIDTH*MASTERS  master addresses, flattened; master i at [i*W +: W], same for all flattened ports.
- m_dat_i  in  DATA_WIDTH*MASTERS  master write data.
- m_cyc_i, m_stb_i, m_we_i  in  MASTERS  master cycle, strobe, write enable.
- m_sel_i  in  SEL_WIDTH*MASTERS  byte selects.
- m_cti_i  in  3*MASTERS; m_bte_i  in  2*MASTERS  burst tags.
- m_dat_o  out  DATA_WIDTH*MASTERS  read data.
- m_ack_o, m_err_o, m_rty_o  out  MASTERS  per-master responses.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o  out  single-slave widths  forwarded request.
- s_cyc_o, s_stb_o  out  1  slave cycle and strobe.
- s_dat_i  in  DATA_WIDTH; s_ack_i, s_err_i, s_rty_i  in  1  slave response.
- grant_o  out  MASTERS  one-hot current owner, or all-zero.

## Operation
- State is a grant register (one-hot or none) plus a `last` index.
- **IDLE (no grant):**
  - All s_* outputs are 0.
  - When any m_cyc_i bit is set, the first requester scanning from last+1 modulo MASTERS is granted at the clock edge.
- **OWNED (grant g):**
  - All s_* request outputs equal master g's fields.
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g].
  - s_dat_i is broadcast to every m_dat_o slice.
  - m_ack_o, m_err_o and m_rty_o are driven only at bit g; all other bits are 0.
- **Release:** in a cycle with m_cyc_i[g]=0, the grant register loads the next round-robin requester, or none if there is no requester, and last=g. No idle state is forced.
- Other masters' requests never preempt an owner while m_cyc_i[g]=1, whatever the value of cti.
- **Watchdog:**
  - Counter width is $clog2(TIMEOUT+1).
  - It increments each cycle with s_cyc_o & s_stb_o & ~(s_ack_i|s_err_i|s_rty_i).
  - It clears on any slave response, on s_stb_o=0, and on a grant change.
  - When counter==TIMEOUT-1 and no response is present, m_err_o[g]=1 for that cycle and the counter clears.
  - A slave response in the same cycle wins: it passes through and no watchdog error is raised.
- Slave err and rty pass through unchanged. The arbiter retries nothing.

## Timing
- Reset values: grant none, last=MASTERS-1 (so master 0 wins first), counter 0.
  - All outputs are 0, including grant_o.
- Reset assertion mid-transfer clears the grant asynchronously; s_cyc_o drops in the same cycle.
- Arbitration latency is 1 cycle: with m_cyc_i rising before edge N, s_cyc_o is high after edge N.
- The request and response paths are combinational once granted: zero added latency per beat.
- Handover between owners: one cycle with s_cyc_o=0 (the releasing cycle), then the new owner is visible.
- With MASTERS=1, the arbiter behaves as a pass-through with 1-cycle initial grant latency.

## Structure
- Shared package wb_pkg holds the CTI constants (CLASSIC 3'b000, CONST 3'b001, INCR 3'b010, EOB 3'b111) and the BTE constants. The arbiter itself uses none of them; they are for the benches.
- One combinational sub-module, arb_rr: inputs are the request vector and last; output is the one-hot next grant. It is reused by other arbiters.
- The watchdog counter and the grant register live in wb_arbiter.

## Test plan
- **Reset:** rst_ni=0, random inputs → every output 0, grant_o=0.
- **Single request:** m_cyc_i=m_stb_i=2'b01 before edge 0.
  - After edge 0: grant_o=01, s_cyc_o=1.
  - Slave acks with s_dat_i=0xDEADBEEF → m_ack_o=01, and slice 0 of m_dat_o reads 0xDEADBEEF.
- **Round robin:** both masters request continuously, each drops cyc after one ack → grant sequence 01, 10, 01, 10, with exactly one s_cyc_o=0 cycle between owners.
- **Lock:** master 0 holds cyc through an 8-beat INCR burst while master 1 requests → grant_o stays 01 for all 8 acks; grant 10 appears the cycle after m_cyc_i[0] falls.
- **Watchdog:** TIMEOUT=4 and the slave is silent → m_err_o[g] pulses in the 4th strobed cycle.
  - Repeated with s_ack_i asserted in that same cycle → only m_ack_o is set.
- **Async reset mid-burst:** rst_ni falls between edges → s_cyc_o drops immediately.
  - After release, with both masters requesting, master 0 is granted first.
